// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port single-port-RAM arbiter.
//   - FSM state encodings (ST_IDLE / ST_ACC / ST_RESP)
//   - Requester port identifiers (PORT0 / PORT1)
//   - RAM operation codes (OP_READ / OP_WRITE)
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester combinational arbiter.
// Ports:
//   req0, req1  in  : request lines
//   last_gnt    in  : port granted most recently
//   gnt_valid   out : at least one request present
//   gnt_id      out : winning port
// Build option: RAM_ARB_FIXED_PRIO_EN defined -> port 0 always wins contention and
// last_gnt is ignored; undefined (default) -> round-robin, the port other than last_gnt
// wins contention.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req0 | req1;

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    gnt_id = req0 ? PORT0 : PORT1;
  end
`else
  always_comb begin
    gnt_id = PORT0;
    if (req0 && req1) begin
      gnt_id = (last_gnt == PORT0) ? PORT1 : PORT0;
    end else if (req1) begin
      gnt_id = PORT1;
    end
  end
`endif

endmodule

// File: rtl/sp_ram.sv
// Single-port RAM with registered read data (read-before-write on the same address).
// Ports:
//   clk     in  : rising-edge clock
//   wr_rdn  in  : 1 = write, 0 = read
//   addr    in  : word address
//   w_data  in  : write data
//   r_data  out : read data, valid one edge after the address is sampled
module sp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_rdn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_rdn) begin
      mem_q[addr] <= w_data;
    end
    r_data <= mem_q[addr];
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between two req/ack requesters, one access at a time.
// Each access takes three cycles: IDLE (arbitrate + latch), ACC (RAM access on the edge
// leaving ACC), RESP (ack pulse to the owner, read data presented).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req0/wr_rdn0/addr0/w_data0   : port 0 request, op, address, write data
//   ack0                         : port 0 completion pulse
//   req1/wr_rdn1/addr1/w_data1   : port 1 equivalents, ack1
//   r_data                       : read data, meaningful only while an ack is high
//   busy                         : FSM not in IDLE
//   ram_wr_rdn/ram_addr/ram_w_data: registered RAM inputs
//   ram_r_data                   : RAM registered read data
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) in rr_arb2.
module sp_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  wr_rdn0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] w_data0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  wr_rdn1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] w_data1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  busy,
  output logic                  ram_wr_rdn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  ram_wr_rdn_q, ram_wr_rdn_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_w_data_q, ram_w_data_d;

  logic gnt_valid;
  logic gnt_id;

  rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_q),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  // State register. The RAM itself has no reset, so a write sitting in ACC on the
  // reset edge still commits; only the arbiter's view is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT0;
      last_gnt_q   <= PORT1;
      ram_wr_rdn_q <= OP_READ;
      ram_addr_q   <= '0;
      ram_w_data_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_gnt_q   <= last_gnt_d;
      ram_wr_rdn_q <= ram_wr_rdn_d;
      ram_addr_q   <= ram_addr_d;
      ram_w_data_q <= ram_w_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_gnt_d   = last_gnt_q;
    ram_wr_rdn_d = ram_wr_rdn_q;
    ram_addr_d   = ram_addr_q;
    ram_w_data_d = ram_w_data_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d    = ST_ACC;
          owner_d    = gnt_id;
          last_gnt_d = gnt_id;
          if (gnt_id == PORT1) begin
            ram_wr_rdn_d = wr_rdn1;
            ram_addr_d   = addr1;
            ram_w_data_d = w_data1;
          end else begin
            ram_wr_rdn_d = wr_rdn0;
            ram_addr_d   = addr0;
            ram_w_data_d = w_data0;
          end
        end
      end
      ST_ACC: begin
        state_d = ST_RESP;
        // RAM samples the write on this same edge, so dropping it here is safe.
        ram_wr_rdn_d = OP_READ;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    ack0       = (state_q == ST_RESP) && (owner_q == PORT0);
    ack1       = (state_q == ST_RESP) && (owner_q == PORT1);
    busy       = (state_q != ST_IDLE);
    r_data     = ram_r_data;
    ram_wr_rdn = ram_wr_rdn_q;
    ram_addr   = ram_addr_q;
    ram_w_data = ram_w_data_q;
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
module tb_sp_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, wr_rdn0 = 1'b0;
  logic [2:0] addr0 = '0;
  logic [7:0] w_data0 = '0;
  logic       req1 = 1'b0, wr_rdn1 = 1'b0;
  logic [2:0] addr1 = '0;
  logic [7:0] w_data1 = '0;
  logic       ack0, ack1, busy, ram_wr_rdn;
  logic [7:0] r_data, ram_w_data, ram_r_data;
  logic [2:0] ram_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sp_ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .wr_rdn0   (wr_rdn0),
    .addr0     (addr0),
    .w_data0   (w_data0),
    .ack0      (ack0),
    .req1      (req1),
    .wr_rdn1   (wr_rdn1),
    .addr1     (addr1),
    .w_data1   (w_data1),
    .ack1      (ack1),
    .r_data    (r_data),
    .busy      (busy),
    .ram_wr_rdn(ram_wr_rdn),
    .ram_addr  (ram_addr),
    .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data)
  );

  sp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) u_ram (
    .clk   (clk),
    .wr_rdn(ram_wr_rdn),
    .addr  (ram_addr),
    .w_data(ram_w_data),
    .r_data(ram_r_data)
  );

  // Ends on a falling edge with rst just released and the FSM in IDLE.
  task automatic do_reset();
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction on a single port; reports cycles from req to ack and read data.
  task automatic access(input bit p, input bit wr, input logic [2:0] a, input logic [7:0] d,
                        output int cyc, output logic [7:0] rd, output bit ok);
    @(negedge clk);
    if (p) begin
      wr_rdn1 = wr; addr1 = a; w_data1 = d; req1 = 1'b1;
    end else begin
      wr_rdn0 = wr; addr0 = a; w_data0 = d; req0 = 1'b1;
    end
    ok  = 1'b0;
    cyc = 0;
    rd  = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((p && ack1) || (!p && ack0)) begin
        ok  = 1'b1;
        cyc = i;
        rd  = r_data;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({ack0, ack1, busy, ram_wr_rdn} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 0000", {ack0, ack1, busy, ram_wr_rdn});
    end
    tests++;
    if (ram_addr !== 3'd0 || ram_w_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_ram_regs: got addr %0d data %h, required 0 / 00", ram_addr,
               ram_w_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int cyc; logic [7:0] rd; bit ok;
    access(1'b0, 1'b1, 3'd3, 8'h0F, cyc, rd, ok);
    tests++;
    if (!ok || cyc != 2) begin
      fails++;
      $display("FAIL wr_latency: got ok=%0d cycles=%0d, required ok=1 cycles=2", ok, cyc);
    end
    access(1'b0, 1'b0, 3'd3, 8'h00, cyc, rd, ok);
    tests++;
    if (!ok || cyc != 2) begin
      fails++;
      $display("FAIL rd_latency: got ok=%0d cycles=%0d, required ok=1 cycles=2", ok, cyc);
    end
    tests++;
    if (rd !== 8'h0F) begin
      fails++;
      $display("FAIL rd_data_addr3: got %h, required 0f", rd);
    end
  endtask

  task automatic test_contention();
    int a0_at = 0, a1_at = 0;
    int cyc; logic [7:0] rd; bit ok;
    bit both = 1'b0;
    do_reset();
    wr_rdn0 = 1'b1; addr0 = 3'd5; w_data0 = 8'hAA; req0 = 1'b1;
    wr_rdn1 = 1'b1; addr1 = 3'd5; w_data1 = 8'h55; req1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack0 && ack1) both = 1'b1;
      if (ack0 && a0_at == 0) begin a0_at = i; req0 = 1'b0; end
      if (ack1 && a1_at == 0) begin a1_at = i; req1 = 1'b0; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tests++;
    if (a0_at != 2 || a1_at != 5 || both) begin
      fails++;
      $display("FAIL contention_order: got ack0@%0d ack1@%0d both=%0d, required 2 / 5 / 0",
               a0_at, a1_at, both);
    end
    access(1'b0, 1'b0, 3'd5, 8'h00, cyc, rd, ok);
    tests++;
    if (!ok || rd !== 8'h55) begin
      fails++;
      $display("FAIL contention_data: got ok=%0d data=%h, required 1 / 55", ok, rd);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_rdn0 = 1'b0; addr0 = 3'd5; req0 = 1'b1;
    wr_rdn1 = 1'b0; addr1 = 3'd3; req1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      bit ea0, ea1, eb;
      @(negedge clk);
      ea0 = (i % 6 == 2);
      ea1 = (i % 6 == 5);
      eb  = (i % 3 != 0);
      tests++;
      if (ack0 !== ea0 || ack1 !== ea1 || busy !== eb) begin
        fails++;
        $display("FAIL rr_cycle%0d: got ack0=%b ack1=%b busy=%b, required %b %b %b", i, ack0,
                 ack1, busy, ea0, ea1, eb);
      end
      if (ea0 || ea1) begin
        tests++;
        if (r_data !== (ea0 ? 8'h55 : 8'h0F)) begin
          fails++;
          $display("FAIL rr_data_cycle%0d: got %h, required %h", i, r_data,
                   ea0 ? 8'h55 : 8'h0F);
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int cyc = 0;
    logic [7:0] rd; bit ok; int c2;
    do_reset();
    wr_rdn1 = 1'b1; addr1 = 3'd2; w_data1 = 8'h33; req1 = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || ram_wr_rdn !== 1'b1 || ram_addr !== 3'd2 || ram_w_data !== 8'h33) begin
      fails++;
      $display("FAIL acc_latch: got busy=%b wr=%b addr=%0d data=%h, required 1 1 2 33", busy,
               ram_wr_rdn, ram_addr, ram_w_data);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (ack1 !== 1'b0 || ram_wr_rdn !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort: got ack1=%b wr=%b busy=%b, required 0 0 0", ack1, ram_wr_rdn, busy);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack1) begin cyc = i; break; end
    end
    req1 = 1'b0;
    tests++;
    if (cyc != 2) begin
      fails++;
      $display("FAIL rearb_after_reset: got ack1 at cycle %0d, required 2", cyc);
    end
    access(1'b0, 1'b0, 3'd2, 8'h00, c2, rd, ok);
    tests++;
    if (!ok || rd !== 8'h33) begin
      fails++;
      $display("FAIL reset_write_data: got ok=%0d data=%h, required 1 / 33", ok, rd);
    end
  endtask

  task automatic test_addr_range();
    int cyc; logic [7:0] rd; bit ok;
    access(1'b0, 1'b1, 3'd7, 8'hC3, cyc, rd, ok);
    access(1'b1, 1'b1, 3'd0, 8'h3C, cyc, rd, ok);
    access(1'b1, 1'b0, 3'd7, 8'h00, cyc, rd, ok);
    tests++;
    if (!ok || rd !== 8'hC3) begin
      fails++;
      $display("FAIL top_addr: got ok=%0d data=%h, required 1 / c3", ok, rd);
    end
    access(1'b0, 1'b0, 3'd0, 8'h00, cyc, rd, ok);
    tests++;
    if (!ok || rd !== 8'h3C) begin
      fails++;
      $display("FAIL bottom_addr: got ok=%0d data=%h, required 1 / 3c", ok, rd);
    end
  endtask

`ifdef RAM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int n0 = 0, n1 = 0, a1_at = 0;
    logic [7:0] d1 = '0;
    do_reset();
    wr_rdn0 = 1'b0; addr0 = 3'd0; req0 = 1'b1;
    wr_rdn1 = 1'b0; addr1 = 3'd7; req1 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (ack0) n0++;
      if (ack1) n1++;
      if (i == 8) req0 = 1'b0;
    end
    tests++;
    if (n0 != 3 || n1 != 0) begin
      fails++;
      $display("FAIL fixed_prio_hold: got ack0 x%0d ack1 x%0d, required 3 / 0", n0, n1);
    end
    for (int i = 10; i <= 20; i++) begin
      @(negedge clk);
      if (ack1) begin a1_at = i; d1 = r_data; break; end
    end
    req1 = 1'b0;
    tests++;
    if (a1_at != 11 || d1 !== 8'hC3) begin
      fails++;
      $display("FAIL fixed_prio_release: got ack1@%0d data=%h, required 11 / c3", a1_at, d1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_contention();
`ifndef RAM_ARB_FIXED_PRIO_EN
    test_back_to_back();
`endif
    test_reset_mid_op();
    test_addr_range();
`ifdef RAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
